serializer_32: RTL and testbench

//   Parallel-in/serial-out transmitter and read side of the Flopenr_32 data path.

---
 rtl/serializer_32.sv | 60 ++++++
 tb/tb_serializer_32.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serializer_32.sv
// serializer_32: valid/ready parallel-in, serial-out shift transmitter
module serializer_32 #(
  parameter int WIDTH = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] D,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0] cnt, cnt_d;
  // state, shift register and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg <= '0;
      cnt <= '0;
    end else begin
      state_q <= state_d;
      shreg <= shreg_d;
      cnt <= cnt_d;
    end
  end
  // load in IDLE; in SHIFT advance one bit per accepted beat, leave after the last
  always_comb begin
    state_d = state_q;
    shreg_d = shreg;
    cnt_d = cnt;
    if (state_q == IDLE) begin
      if (load_valid) begin
        shreg_d = D;
        cnt_d = CW'(WIDTH - 1);
        state_d = SHIFT;
      end
    end else if (sout_ready) begin
      if (cnt == '0) begin
        shreg_d = '0;
        state_d = IDLE;
      end else begin
        shreg_d = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        cnt_d = cnt - CW'(1);
      end
    end
  end
  assign busy = (state_q == SHIFT);
  assign load_ready = (state_q == IDLE);
  assign sout_valid = busy;
  assign sout = busy & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign sout_last = busy & (cnt == '0);
endmodule

// File: tb/tb_serializer_32.sv
// tb_serializer_32: directed checks of the 32-bit MSB-first and 8-bit LSB-first serializers
module tb_serializer_32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lv = 1'b0, rdy = 1'b0;
  logic [31:0] d = '0;
  logic lr, so, sv, sl, bz;
  logic lv8 = 1'b0, rdy8 = 1'b0;
  logic [7:0] d8 = '0;
  logic lr8, so8, sv8, sl8, bz8;
  int tests = 0, fails = 0;
  logic [31:0] got;
  logic [7:0] got8;
  int beats;

  always #5 clk = ~clk;

  serializer_32 #(.WIDTH(32), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .load_valid(lv), .load_ready(lr), .D(d),
    .sout(so), .sout_valid(sv), .sout_ready(rdy), .sout_last(sl), .busy(bz)
  );

  serializer_32 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(lr8), .D(d8),
    .sout(so8), .sout_valid(sv8), .sout_ready(rdy8), .sout_last(sl8), .busy(bz8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    lv = 1'b1;
    d = w;
    step();
    lv = 1'b0;
    d = $urandom;
    chk("first_bit_valid", {31'b0, sv}, 32'd1);
    chk("ready_low_in_shift", {31'b0, lr}, 32'd0);
  endtask

  // collect one word; bp selects ready pattern 1,0,0,1,0,0...; pulse_at injects a load request at that beat
  task automatic recv(input bit bp, input int pulse_at, output logic [31:0] w, output int n);
    int cyc;
    logic prev;
    w = '0;
    n = 0;
    cyc = 0;
    while (sv && cyc < 200) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      lv = (n == pulse_at);
      d = (n == pulse_at) ? 32'h12345678 : d;
      chk("last_flag", {31'b0, sl}, {31'b0, n == 31});
      prev = so;
      if (rdy) begin
        w = {w[30:0], so};
        n++;
      end
      step();
      lv = 1'b0;
      if (!rdy) chk("hold_on_stall", {31'b0, so}, {31'b0, prev});
      cyc++;
    end
    rdy = 1'b0;
    chk("word_completes", {31'b0, cyc < 200}, 32'd1);
  endtask

  initial begin
    // 1: asynchronous reset, checked before any clock edge
    lv = $urandom;
    rdy = $urandom;
    d = $urandom;
    lv8 = $urandom;
    rdy8 = $urandom;
    #1 reset = 1'b0;
    #1;
    chk("rst_load_ready", {31'b0, lr}, 32'd1);
    chk("rst_sout_valid", {31'b0, sv}, 32'd0);
    chk("rst_sout", {31'b0, so}, 32'd0);
    chk("rst_busy", {31'b0, bz}, 32'd0);
    chk("rst_last", {31'b0, sl}, 32'd0);
    chk("rst8_ready_valid", {30'b0, lr8, sv8}, 32'd2);
    lv = 1'b0;
    rdy = 1'b0;
    lv8 = 1'b0;
    rdy8 = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
    chk("idle_after_release", {30'b0, lr, bz}, 32'd2);
    // 2: 0x5E MSB first at full rate
    load(32'h0000005E);
    recv(1'b0, -1, got, beats);
    chk("msb_stream_5e", got, 32'h0000005E);
    chk("msb_beats_5e", beats, 32);
    chk("ready_after_word", {31'b0, lr}, 32'd1);
    chk("not_busy_after_word", {31'b0, bz}, 32'd0);
    chk("sout_zero_idle", {31'b0, so}, 32'd0);
    // 3: backpressure
    load(32'hA5A5A5A5);
    recv(1'b1, -1, got, beats);
    chk("bp_stream", got, 32'hA5A5A5A5);
    chk("bp_beats", beats, 32);
    // 4: load request while busy is ignored
    load(32'hFFFF0000);
    recv(1'b0, 5, got, beats);
    chk("busy_load_stream", got, 32'hFFFF0000);
    chk("busy_load_idle", {30'b0, lr, sv}, 32'd2);
    step();
    step();
    chk("no_second_word", {30'b0, sv, bz}, 32'd0);
    // 5: reset mid-word
    load(32'hDEADBEEF);
    rdy = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("mid_still_busy", {31'b0, bz}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid_drop", {31'b0, sv}, 32'd0);
    chk("abort_ready", {31'b0, lr}, 32'd1);
    chk("abort_sout", {31'b0, so}, 32'd0);
    rdy = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
    load(32'h00000001);
    recv(1'b0, -1, got, beats);
    chk("post_abort_stream", got, 32'h00000001);
    chk("post_abort_beats", beats, 32);
    // 6: WIDTH=8, LSB first, 0x5E gives 0,1,1,1,1,0,1,0
    lv8 = 1'b1;
    d8 = 8'h5E;
    step();
    lv8 = 1'b0;
    d8 = 8'h00;
    rdy8 = 1'b1;
    got8 = '0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_valid", {31'b0, sv8}, 32'd1);
      chk("lsb_last", {31'b0, sl8}, {31'b0, i == 7});
      got8 = {got8[6:0], so8};
      step();
    end
    rdy8 = 1'b0;
    chk("lsb_stream", {24'b0, got8}, 32'h0000007A);
    chk("lsb_ready_after", {30'b0, lr8, bz8}, 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
